exu_iter: RTL and testbench

- Parametrised next-generation execute unit for the NPC core.
- Widens the opcode set of the existing single-cycle ALU: add/sub, pass-through, snpc, logic, shifts, compares.
- Adds iterative multiply, unsigned divide and unsigned remainder.
- Sits between decode/regfile read and writeback; valid/ready handshakes on both sides so the core can stall on multi-cycle ops.

---
 rtl/exu_iter.sv | 229 ++++++++++++++++++++++
 tb/tb_exu_iter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_iter.sv
// exu_iter: execute unit for the NPC core.
//
// Single-cycle ALU operations:
//   add, sub, pass-through, snpc, logic, shifts, compares.
// Iterative operations:
//   shift-add multiply (low XLEN bits) and restoring unsigned divide/remainder.
//
// The unit sits between register read and writeback, with valid/ready
// handshakes on both sides. A new operation can be accepted in the same cycle
// the previous result is taken.
//
// Ports:
//   clk_i        core clock
//   rst_i        synchronous active-high reset
//   in_valid_i   operation presented
//   in_ready_o   operation accepted this cycle when in_valid_i is also high
//   op_i         opcode (0..15)
//   src1_i       operand 1
//   src2_i       operand 2
//   snpc_i       static next PC
//   sum_o        combinational src1+src2 (src1-src2 for SUB), address path
//   out_valid_o  result available
//   out_ready_i  consumer takes the result
//   result_o     registered result, held until taken
//   busy_o       high while a multiply or divide is iterating

module exu_iter #(
  parameter int XLEN   = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic [XLEN-1:0] snpc_i,
  output logic [XLEN-1:0] sum_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_PASS1 = 4'd2;
  localparam logic [3:0] OP_PASS2 = 4'd3;
  localparam logic [3:0] OP_SNPC  = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_SLT   = 4'd11;
  localparam logic [3:0] OP_SLTU  = 4'd12;
  localparam logic [3:0] OP_MUL   = 4'd13;
  localparam logic [3:0] OP_DIVU  = 4'd14;
  localparam logic [3:0] OP_REMU  = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] result_q;
  logic            out_valid_q;
  logic            busy_q;
  // Operand A: multiplicand (MUL) or dividend shifting into quotient (DIV).
  logic [XLEN-1:0] opa_q;
  // Operand B: multiplier (MUL) or divisor (DIV).
  logic [XLEN-1:0] opb_q;
  // Accumulator (MUL) or partial remainder (DIV).
  logic [XLEN-1:0] acc_q;
  logic            is_rem_q;
  logic [CW-1:0]   cnt_q;

  logic            accept;
  logic            last_step;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            go_mul;
  logic            go_div;

  logic [XLEN-1:0] mul_acc_d;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_trial;
  logic            div_ge;
  logic [XLEN-1:0] div_rem_d;
  logic [XLEN-1:0] div_quo_d;

  // Address path, independent of the sequencing FSM.
  assign sum_o = (op_i == OP_SUB) ? (src1_i - src2_i) : (src1_i + src2_i);

  assign in_ready_o  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign busy_o      = busy_q;

  assign shamt     = src2_i[SHW-1:0];
  assign last_step = (cnt_q == CW'(XLEN - 1));

  // A zero divisor short-circuits to a one-cycle result.
  assign go_mul = MUL_EN && (op_i == OP_MUL);
  assign go_div = MUL_EN && ((op_i == OP_DIVU) || (op_i == OP_REMU)) && (src2_i != '0);

  always_comb begin
    alu_res = '0;
    unique case (op_i)
      OP_ADD:   alu_res = src1_i + src2_i;
      OP_SUB:   alu_res = src1_i - src2_i;
      OP_PASS1: alu_res = src1_i;
      OP_PASS2: alu_res = src2_i;
      OP_SNPC:  alu_res = snpc_i;
      OP_AND:   alu_res = src1_i & src2_i;
      OP_OR:    alu_res = src1_i | src2_i;
      OP_XOR:   alu_res = src1_i ^ src2_i;
      OP_SLL:   alu_res = src1_i << shamt;
      OP_SRL:   alu_res = src1_i >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(src1_i) >>> shamt);
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (src1_i < src2_i)};
      OP_MUL:   alu_res = '0;
      OP_DIVU:  alu_res = MUL_EN ? '1 : '0;
      OP_REMU:  alu_res = MUL_EN ? src1_i : '0;
      default:  alu_res = '0;
    endcase
  end

  // One shift-add multiply step.
  assign mul_acc_d = opb_q[0] ? (acc_q + opa_q) : acc_q;

  // One restoring divide step. The shifted remainder is below twice the
  // divisor, so it fits in XLEN+1 bits and the trial subtraction's top bit
  // tells whether the divisor fits.
  assign div_shift = {acc_q, opa_q[XLEN-1]};
  assign div_trial = div_shift - {1'b0, opb_q};
  assign div_ge    = ~div_trial[XLEN];
  assign div_rem_d = div_ge ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_quo_d = {opa_q[XLEN-2:0], div_ge};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      is_rem_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (go_mul) begin
              opa_q       <= src1_i;
              opb_q       <= src2_i;
              acc_q       <= '0;
              cnt_q       <= '0;
              state_q     <= S_MUL;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b1;
            end else if (go_div) begin
              opa_q       <= src1_i;
              opb_q       <= src2_i;
              acc_q       <= '0;
              cnt_q       <= '0;
              is_rem_q    <= (op_i == OP_REMU);
              state_q     <= S_DIV;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b1;
            end else begin
              result_q    <= alu_res;
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end else if ((state_q == S_DONE) && out_ready_i) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end

        S_MUL: begin
          acc_q <= mul_acc_d;
          opa_q <= opa_q << 1;
          opb_q <= opb_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) begin
            result_q    <= mul_acc_d;
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        S_DIV: begin
          acc_q <= div_rem_d;
          opa_q <= div_quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) begin
            result_q    <= is_rem_q ? div_rem_d : div_quo_d;
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exu_iter.sv
// tb_exu_iter: self-checking bench for exu_iter (XLEN=64, MUL_EN=1).
// Expected results are queued when an operation is issued and compared by a
// monitor whenever a result is taken; scenario tasks add inline checks of
// latency, handshake and status signals.

module tb_exu_iter;

  localparam int XLEN = 64;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_PASS1 = 4'd2;
  localparam logic [3:0] OP_PASS2 = 4'd3;
  localparam logic [3:0] OP_SNPC  = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_SLT   = 4'd11;
  localparam logic [3:0] OP_SLTU  = 4'd12;
  localparam logic [3:0] OP_MUL   = 4'd13;
  localparam logic [3:0] OP_DIVU  = 4'd14;
  localparam logic [3:0] OP_REMU  = 4'd15;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SNPC = 64'h0000_0000_8000_1004;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [XLEN-1:0] snpc;
  logic [XLEN-1:0] sum;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] sb_exp;

  exu_iter #(.XLEN(XLEN), .MUL_EN(1'b1)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .src1_i      (src1),
    .src2_i      (src2),
    .snpc_i      (snpc),
    .sum_o       (sum),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: each result taken by the consumer must match the oldest
  // expected value.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: unexpected result %h, nothing expected", result);
      end else begin
        sb_exp = exp_q.pop_front();
        if (result !== sb_exp) begin
          n_fail++;
          $display("FAIL scoreboard: result %h, expected %h", result, sb_exp);
        end
      end
    end
  end

  // Present one operation, queue its expected result, and leave the bench
  // 1 time unit after the accepting edge. The caller guarantees in_ready.
  task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input bit push);
    in_valid = 1'b1;
    op       = o;
    src1     = a;
    src2     = b;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count cycles from the accepting edge until out_valid, along with the
  // busy cycles and any cycles where in_ready was wrongly high. Returns just
  // after the edge on which the result is taken.
  task automatic wait_out(output int lat, output int busy_cnt, output int rdy_bad);
    lat      = 1;
    busy_cnt = 0;
    rdy_bad  = 0;
    while (lat <= 200) begin
      @(negedge clk);
      if (out_valid) break;
      if (busy) busy_cnt++;
      if (in_ready) rdy_bad++;
      lat++;
    end
    if (lat > 200) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = OP_ADD;
    src1      = '0;
    src2      = '0;
    snpc      = SNPC;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy, in_ready} !== 3'b001 || result !== 64'd0) begin
      n_fail++;
      $display("FAIL reset: valid/busy/ready=%b result=%h, expected 001 and 0",
               {out_valid, busy, in_ready}, result);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = OP_ADD;
    src1      = 64'd5;
    src2      = 64'd7;
    exp_q.push_back(64'd12);
    #1;
    n_checks++;
    if (sum !== 64'd12) begin
      n_fail++;
      $display("FAIL b2b_sum_add: sum %h, expected %h", sum, 64'd12);
    end
    @(posedge clk);
    #1;
    op = OP_SUB;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    n_checks++;
    if (sum !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_fail++;
      $display("FAIL b2b_sum_sub: sum %h, expected %h", sum, 64'hFFFF_FFFF_FFFF_FFFE);
    end
    n_checks++;
    if (out_valid !== 1'b1 || result !== 64'd12 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%b ready=%b result=%h, expected 1 1 %h",
               out_valid, in_ready, result, 64'd12);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || result !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%b result=%h, expected 1 %h",
               out_valid, result, 64'hFFFF_FFFF_FFFF_FFFE);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: out_valid %b, expected 0", out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_stream();
    logic [3:0]  t_op [14];
    logic [63:0] t_a  [14];
    logic [63:0] t_b  [14];
    logic [63:0] t_e  [14];
    int          guard;
    t_op = '{OP_ADD, OP_SUB, OP_PASS1, OP_PASS2, OP_SNPC, OP_AND, OP_OR,
             OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_SLT};
    t_a  = '{ONES, 64'd0, 64'h1234, 64'h1234, 64'h1234, 64'hF0F0, 64'hF0F0,
             64'hF0F0, 64'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
             ONES, ONES, 64'd1};
    t_b  = '{64'd1, 64'd1, 64'h5678, 64'h5678, 64'h5678, 64'hFF00, 64'hFF00,
             64'hFF00, 64'h7F, 64'h43, 64'h43, 64'd1, 64'd1, ONES};
    t_e  = '{64'd0, ONES, 64'h1234, 64'h5678, SNPC, 64'hF000, 64'hFFF0,
             64'h0FF0, 64'h8000_0000_0000_0000, 64'h1000_0000_0000_0000,
             64'hF000_0000_0000_0000, 64'd1, 64'd0, 64'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1;
      op       = t_op[i];
      src1     = t_a[i];
      src2     = t_b[i];
      exp_q.push_back(t_e[i]);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL alu_stream_drain: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_mul();
    int lat, bc, rb;
    out_ready = 1'b1;
    issue(OP_MUL, ONES, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
    wait_out(lat, bc, rb);
    n_checks++;
    if (lat !== 65 || bc !== 64 || rb !== 0) begin
      n_fail++;
      $display("FAIL mul_timing: latency %0d busy %0d ready_high %0d, expected 65 64 0",
               lat, bc, rb);
    end
  endtask

  task automatic test_div();
    int lat, bc, rb;
    out_ready = 1'b1;
    issue(OP_DIVU, 64'd100, 64'd7, 64'd14, 1'b1);
    wait_out(lat, bc, rb);
    n_checks++;
    if (lat !== 65 || bc !== 64 || rb !== 0) begin
      n_fail++;
      $display("FAIL divu_timing: latency %0d busy %0d ready_high %0d, expected 65 64 0",
               lat, bc, rb);
    end
    issue(OP_REMU, 64'd100, 64'd7, 64'd2, 1'b1);
    wait_out(lat, bc, rb);
    n_checks++;
    if (lat !== 65 || bc !== 64) begin
      n_fail++;
      $display("FAIL remu_timing: latency %0d busy %0d, expected 65 64", lat, bc);
    end
    issue(OP_DIVU, 64'h1234_5678, 64'd0, ONES, 1'b1);
    wait_out(lat, bc, rb);
    n_checks++;
    if (lat !== 1 || bc !== 0) begin
      n_fail++;
      $display("FAIL divu_zero_timing: latency %0d busy %0d, expected 1 0", lat, bc);
    end
    issue(OP_REMU, 64'd9, 64'd0, 64'd9, 1'b1);
    wait_out(lat, bc, rb);
    n_checks++;
    if (lat !== 1 || bc !== 0) begin
      n_fail++;
      $display("FAIL remu_zero_timing: latency %0d busy %0d, expected 1 0", lat, bc);
    end
  endtask

  task automatic test_random_iter();
    int          lat, bc, rb;
    logic [63:0] a, b, e;
    logic [3:0]  o;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()} >> $urandom_range(63, 0);
      if (b == 64'd0) b = 64'd3;
      case (i % 3)
        0:       begin o = OP_MUL;  e = a * b; end
        1:       begin o = OP_DIVU; e = a / b; end
        default: begin o = OP_REMU; e = a % b; end
      endcase
      issue(o, a, b, e, 1'b1);
      wait_out(lat, bc, rb);
      n_checks++;
      if (lat !== 65) begin
        n_fail++;
        $display("FAIL random_iter_latency: op %0d latency %0d, expected 65", o, lat);
      end
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    issue(OP_ADD, 64'd1, 64'd1, 64'd2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || result !== 64'd2 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d valid=%b ready=%b result=%h, expected 1 0 %h",
                 i, out_valid, in_ready, result, 64'd2);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: ready=%b valid=%b, expected 1 1", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort();
    int lat, bc, rb;
    out_ready = 1'b1;
    issue(OP_MUL, 64'd6, 64'd7, 64'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy: busy=%b ready=%b, expected 1 0", busy, in_ready);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy, in_ready} !== 3'b001 || result !== 64'd0) begin
      n_fail++;
      $display("FAIL abort_state: valid/busy/ready=%b result=%h, expected 001 and 0",
               {out_valid, busy, in_ready}, result);
    end
    #1;
    issue(OP_ADD, 64'd2, 64'd2, 64'd4, 1'b1);
    wait_out(lat, bc, rb);
    n_checks++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL abort_followup_latency: latency %0d, expected 1", lat);
    end
    repeat (80) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_no_output: valid=%b outstanding=%0d, expected 0 0",
               out_valid, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_alu_stream();
    test_mul();
    test_div();
    test_random_iter();
    test_stall();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
